dcsk_modulator: RTL and testbench

// - DCSK transmit stage that directly feeds Demod_Top's In_Mod_Data/Valid inputs.
// - Accepts 32-bit information words over a valid/ready handshake and serialises them LSB first.
// - Per bit: beta chaotic reference chips (LFSR), then beta data chips (reference if bit=1, inverted if bit=0).
// - One chip per clock.

---
 rtl/dcsk_modulator.sv | 94 +++++++++
 tb/tb_dcsk_modulator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dcsk_modulator.sv
// dcsk_modulator: DCSK transmitter, per bit beta LFSR reference chips then beta data chips, LSB first.
// Optional: define DCSK_MOD_RESEED_EN to reload LFSR_SEED on every word accept.
module dcsk_modulator #(
    parameter int          WORDLEN   = 32,
    parameter int          MAX_BETA  = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [WORDLEN-1:0] In_Data,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [1:0]         Spread_Factor_Sel,
    output logic               Out_Mod_Data,
    output logic               Out_Valid,
    output logic               Out_Word_Done
);
    localparam int CW = $clog2(MAX_BETA);
    localparam int BW = $clog2(WORDLEN);

    typedef enum logic [1:0] {IDLE, REF, DATA} state_t;

    state_t             st, n_st;
    logic [CW-1:0]      chip_cnt, n_chip, bm1, n_bm1;
    logic [BW-1:0]      bit_cnt, n_bit;
    logic [1:0]         sel, n_sel;
    logic [WORDLEN-1:0] word, n_word;
    logic [15:0]        lfsr, lsrc;
    logic               ref_buf [MAX_BETA];
    logic               accept, last, n_last;

    // Next-chip position is decoded here so every output can be registered from it.
    always_comb begin
        accept = In_Valid && In_Ready;
        bm1    = CW'((32'd2 << sel) - 32'd1);
        last   = st == DATA && chip_cnt == bm1 && bit_cnt == BW'(WORDLEN - 1);
        n_st   = st;
        n_chip = chip_cnt + 1'b1;
        n_bit  = bit_cnt;
        n_sel  = sel;
        n_word = word;
        if (accept) begin
            n_st   = REF;
            n_chip = '0;
            n_bit  = '0;
            n_sel  = Spread_Factor_Sel;
            n_word = In_Data;
        end else if (st == IDLE || last) begin
            n_st   = IDLE;
            n_chip = '0;
        end else if (chip_cnt == bm1) begin
            n_st   = st == REF ? DATA : REF;
            n_chip = '0;
            n_bit  = st == DATA ? bit_cnt + 1'b1 : bit_cnt;
        end
        n_bm1  = CW'((32'd2 << n_sel) - 32'd1);
        n_last = n_st == DATA && n_chip == n_bm1 && n_bit == BW'(WORDLEN - 1);
`ifdef DCSK_MOD_RESEED_EN
        lsrc   = accept ? LFSR_SEED : lfsr;
`else
        lsrc   = lfsr;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            st            <= IDLE;
            chip_cnt      <= '0;
            bit_cnt       <= '0;
            sel           <= '0;
            word          <= '0;
            lfsr          <= LFSR_SEED;
            Out_Mod_Data  <= 1'b0;
            Out_Valid     <= 1'b0;
            Out_Word_Done <= 1'b0;
            In_Ready      <= 1'b1;
        end else begin
            st            <= n_st;
            chip_cnt      <= n_chip;
            bit_cnt       <= n_bit;
            sel           <= n_sel;
            word          <= n_word;
            Out_Valid     <= n_st != IDLE;
            Out_Word_Done <= n_last;
            In_Ready      <= n_st == IDLE || n_last;
            Out_Mod_Data  <= n_st == REF  ? lsrc[0] :
                             n_st == DATA ? ~(ref_buf[n_chip] ^ n_word[n_bit]) : 1'b0;
            if (n_st == REF) begin
                ref_buf[n_chip] <= lsrc[0];
                lfsr            <= {lsrc[0] ^ lsrc[2] ^ lsrc[3] ^ lsrc[5], lsrc[15:1]};
            end
        end
    end
endmodule

// File: tb/tb_dcsk_modulator.sv
// tb_dcsk_modulator: directed checks of chip stream, word framing, handshake and reset abort.
module tb_dcsk_modulator;
    logic        clk, rst, in_valid, in_ready, mod_data, out_valid, word_done;
    logic [31:0] in_data;
    logic [1:0]  sel;

    dcsk_modulator dut (
        .Clk(clk), .Rst(rst), .In_Data(in_data), .In_Valid(in_valid), .In_Ready(in_ready),
        .Spread_Factor_Sel(sel), .Out_Mod_Data(mod_data), .Out_Valid(out_valid),
        .Out_Word_Done(word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0, nbad = 0;
    logic cap_chip [0:1023];
    int   cap_n, cap_done, cap_rdy_bad, cap_gap;
    logic exp_chip [0:1023];
    int   exp_n;
    logic [15:0] m_lfsr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            nbad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic model_word(input logic [31:0] d, input logic [1:0] s);
        int   b;
        logic rb [0:15];
        b = 2 << s;
`ifdef DCSK_MOD_RESEED_EN
        m_lfsr = 16'hACE1;
`endif
        exp_n = 0;
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < b; k++) begin
                rb[k] = m_lfsr[0];
                exp_chip[exp_n] = m_lfsr[0];
                exp_n++;
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            end
            for (int k = 0; k < b; k++) begin
                exp_chip[exp_n] = d[i] ? rb[k] : ~rb[k];
                exp_n++;
            end
        end
    endtask

    task automatic start_word(input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        in_data = d;
        sel = s;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
        chk("start_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Samples one word; on its first chip the inputs switch to the given next values.
    task automatic capture(input logic nv, input logic [31:0] nd, input logic [1:0] ns, input int abort_at);
        cap_n = 0; cap_done = 0; cap_rdy_bad = 0; cap_gap = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b1) begin
                cap_gap = 1;
                break;
            end
            cap_chip[cap_n] = mod_data;
            cap_n++;
            if (word_done === 1'b1 && cap_done == 0) cap_done = cap_n;
            if (in_ready !== word_done) cap_rdy_bad++;
            if (c == 0) begin
                in_valid = nv;
                in_data = nd;
                sel = ns;
            end
            if (word_done === 1'b1) break;
            if (cap_n == abort_at) begin
                rst = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_word(input string tag, input int exp_len, input int exp_done);
        int bad, first;
        bad = 0;
        first = -1;
        for (int i = 0; i < cap_n && i < exp_n; i++)
            if (cap_chip[i] !== exp_chip[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        total++;
        assert (bad === 0) else begin
            nbad++;
            $error("FAIL %s_chips: got %0d wrong chips (first %0d) expected 0", tag, bad, first);
        end
        chk({tag, "_len"}, cap_n, exp_len);
        chk({tag, "_done_at"}, cap_done, exp_done);
        chk({tag, "_ready"}, cap_rdy_bad, 0);
        chk({tag, "_gap"}, cap_gap, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a12;
        logic [15:0] g16;
        int          halves;
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; sel = 2'b11;
        m_lfsr = 16'hACE1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_data", {31'd0, mod_data}, 32'd0);
            chk("rst_ready", {31'd0, in_ready}, 32'd1);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("no_accept_in_rst", {31'd0, out_valid}, 32'd0);

        // beta=2, data=1: first 12 chips 1,0,1,0, 0,0,1,1, 0,1,1,0
        start_word(32'h1, 2'b00);
        capture(1'b0, 32'h0, 2'b00, 0);
        model_word(32'h1, 2'b00);
        check_word("a", 128, 128);
        for (int i = 0; i < 12; i++) a12[i] = cap_chip[i];
        chk("a_first12", {20'd0, a12}, 32'h6C5);

        // beta=16 all ones, next word (beta=2) held valid throughout
        start_word(32'hFFFF_FFFF, 2'b11);
        capture(1'b1, 32'hA5C3_0F96, 2'b00, 0);
        model_word(32'hFFFF_FFFF, 2'b11);
        check_word("b", 1024, 1024);
        halves = 0;
        for (int i = 0; i < 32; i++)
            for (int k = 0; k < 16; k++)
                if (cap_chip[i * 32 + 16 + k] !== cap_chip[i * 32 + k]) halves++;
        chk("b_halves", halves, 0);

        capture(1'b0, 32'h0, 2'b00, 0);
        model_word(32'hA5C3_0F96, 2'b00);
        check_word("c_b2b", 128, 128);

        // beta=8 with Sel moved to 00 during the word
        start_word(32'h1234_5678, 2'b10);
        capture(1'b0, 32'h0, 2'b00, 0);
        model_word(32'h1234_5678, 2'b10);
        check_word("d", 512, 512);
        @(negedge clk);
        chk("d_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("d_idle_ready", {31'd0, in_ready}, 32'd1);

        start_word(32'h8000_0001, 2'b01);
        capture(1'b0, 32'h0, 2'b11, 0);
        model_word(32'h8000_0001, 2'b01);
        check_word("e", 256, 256);

        // beta=8 aborted by reset after chip 100
        start_word(32'hCAFE_F00D, 2'b10);
        capture(1'b0, 32'h0, 2'b10, 100);
        model_word(32'hCAFE_F00D, 2'b10);
        check_word("f_abort", 100, 0);
        @(negedge clk);
        chk("f_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("f_rst_data", {31'd0, mod_data}, 32'd0);
        chk("f_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("f_rst_done", {31'd0, word_done}, 32'd0);
        rst = 1'b0;
        m_lfsr = 16'hACE1;

        // after reset the reference restarts at the seed: chips = ACE1 bits, data half inverted
        start_word(32'h0, 2'b11);
        capture(1'b0, 32'h0, 2'b11, 0);
        model_word(32'h0, 2'b11);
        check_word("g", 1024, 1024);
        for (int i = 0; i < 16; i++) g16[i] = cap_chip[i];
        chk("g_ref_seed", {16'd0, g16}, 32'hACE1);
        for (int i = 0; i < 16; i++) g16[i] = cap_chip[16 + i];
        chk("g_data_inv", {16'd0, g16}, 32'h531E);

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule
